// File: rtl/dcw_config_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcw_config_seq_if
//  Description : Request/response bundle between a configuration requester
//                and the data-channel-wrapper configuration sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dcw_config_seq_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_width;
    logic [2:0]  cfg_width_alt;
    logic        cfg_use_alt;
    logic [24:0] cfg_clk_val;
    logic        abort;
    logic [2:0]  ctrl_sig;
    logic [2:0]  val;
    logic [2:0]  val1;
    logic [24:0] wanted_cl_val;
    logic [24:0] earlier_cl_val;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output cfg_valid, cfg_width, cfg_width_alt, cfg_use_alt, cfg_clk_val, abort,
        input  cfg_ready, ctrl_sig, val, val1, wanted_cl_val, earlier_cl_val,
               busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_width, cfg_width_alt, cfg_use_alt, cfg_clk_val, abort,
        output cfg_ready, ctrl_sig, val, val1, wanted_cl_val, earlier_cl_val,
               busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/dcw_config_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dcw_config_seq
//  Description : Sequences a datawidth / reference-clock change on the data
//                channel wrapper: reset, release, optional alt phase, done.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcw_config_seq #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  wire logic          clock,
    input  wire logic          rst_n,
    dcw_config_seq_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_REL  = 3'd2,
        S_ALT  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [7:0] c_RST_LAST    = 8'(RESET_CYCLES - 1);
    localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [2:0] c_CTRL_RST    = 3'd1;
    localparam logic [2:0] c_CTRL_REL    = 3'd2;
    localparam logic [2:0] c_CTRL_ALT    = 3'd3;

    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_use_alt, w_use_alt;
    logic [2:0]  r_ctrl_sig, w_ctrl_sig;
    logic [2:0]  r_val, w_val;
    logic [2:0]  r_val1, w_val1;
    logic [24:0] r_wanted, w_wanted;
    logic [24:0] r_earlier, w_earlier;
    logic        r_busy, r_done, r_err, r_ready;
    logic        w_err;
    logic        w_bad;

    // Width codes 1..4 are the only ones the wrapper understands.
    always_comb begin
        w_bad = (bus.cfg_width == 3'd0) || (bus.cfg_width > 3'd4) ||
                (bus.cfg_use_alt &&
                 ((bus.cfg_width_alt == 3'd0) || (bus.cfg_width_alt > 3'd4)));
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_use_alt = r_use_alt;
        w_val     = r_val;
        w_val1    = r_val1;
        w_wanted  = r_wanted;
        w_earlier = r_earlier;
        w_err     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    if (w_bad) begin
                        w_err = 1'b1;
                    end else begin
                        w_val     = bus.cfg_width;
                        w_val1    = bus.cfg_width_alt;
                        w_use_alt = bus.cfg_use_alt;
                        w_earlier = r_wanted;
                        w_wanted  = bus.cfg_clk_val;
                        w_cnt     = 8'd0;
                        w_state   = S_RST;
                    end
                end
            end
            S_RST: begin
                if (bus.abort) begin
                    w_cnt   = 8'd0;
                    w_state = S_RST;
                end else if (r_cnt == c_RST_LAST) begin
                    w_cnt   = 8'd0;
                    w_state = S_REL;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_REL: begin
                if (bus.abort) begin
                    w_cnt   = 8'd0;
                    w_state = S_RST;
                end else if (r_cnt == c_SETTLE_LAST) begin
                    w_cnt   = 8'd0;
                    w_state = r_use_alt ? S_ALT : S_FIN;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_ALT: begin
                if (bus.abort) begin
                    w_cnt   = 8'd0;
                    w_state = S_RST;
                end else if (r_cnt == c_SETTLE_LAST) begin
                    w_cnt   = 8'd0;
                    w_state = S_FIN;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_FIN: begin
                w_cnt   = 8'd0;
                w_state = S_IDLE;
            end
            default: begin
                w_cnt   = 8'd0;
                w_state = S_IDLE;
            end
        endcase

        // ctrl_sig follows the state being entered; IDLE and FIN keep the last command.
        unique case (w_state)
            S_RST:   w_ctrl_sig = c_CTRL_RST;
            S_REL:   w_ctrl_sig = c_CTRL_REL;
            S_ALT:   w_ctrl_sig = c_CTRL_ALT;
            default: w_ctrl_sig = r_ctrl_sig;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_use_alt  <= 1'b0;
            r_ctrl_sig <= c_CTRL_RST;
            r_val      <= 3'd0;
            r_val1     <= 3'd0;
            r_wanted   <= 25'd0;
            r_earlier  <= 25'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_use_alt  <= w_use_alt;
            r_ctrl_sig <= w_ctrl_sig;
            r_val      <= w_val;
            r_val1     <= w_val1;
            r_wanted   <= w_wanted;
            r_earlier  <= w_earlier;
            r_busy     <= (w_state != S_IDLE);
            r_done     <= (w_state == S_FIN);
            r_err      <= w_err;
            r_ready    <= (w_state == S_IDLE);
        end
    end

    assign bus.cfg_ready      = r_ready;
    assign bus.ctrl_sig       = r_ctrl_sig;
    assign bus.val            = r_val;
    assign bus.val1           = r_val1;
    assign bus.wanted_cl_val  = r_wanted;
    assign bus.earlier_cl_val = r_earlier;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dcw_config_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcw_config_seq
//  Description : Directed self-checking bench for dcw_config_seq (defaults
//                RESET_CYCLES=16, SETTLE_CYCLES=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcw_config_seq;

    logic clock;
    logic rst_n;
    int   vectors;
    int   miscompares;

    dcw_config_seq_if bus ();

    dcw_config_seq #(
        .RESET_CYCLES  (16),
        .SETTLE_CYCLES (8)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            $error("miscompare on %s", tag);
        end
    endtask

    // Present one request for a single edge; returns with the first post-accept sample.
    task automatic request(input logic [2:0] w, input logic [2:0] wa, input logic ua,
                           input logic [24:0] cv);
        bus.cfg_width     = w;
        bus.cfg_width_alt = wa;
        bus.cfg_use_alt   = ua;
        bus.cfg_clk_val   = cv;
        bus.cfg_valid     = 1'b1;
        tick();
        bus.cfg_valid     = 1'b0;
    endtask

    // Called on sample 1 after an accept (or abort) edge; counts phases until done.
    task automatic run_and_check(input string tag, input int e1, input int e2,
                                 input int e3, input int elat, input logic [2:0] elast);
        int c1 = 0, c2 = 0, c3 = 0, lat = 0;
        bit seen = 1'b0;
        for (int n = 1; n <= 200 && !seen; n++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                case (bus.ctrl_sig)
                    3'd1: c1++;
                    3'd2: c2++;
                    3'd3: c3++;
                    default: ;
                endcase
                tick();
            end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, lat, elat);
        chk({tag, " ctrl1_cycles"}, c1, e1);
        chk({tag, " ctrl2_cycles"}, c2, e2);
        chk({tag, " ctrl3_cycles"}, c3, e3);
        chk({tag, " fin_ctrl_hold"}, 32'(bus.ctrl_sig), 32'(elast));
        tick();
        chk({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, " idle_ready"}, 32'(bus.cfg_ready), 32'd1);
        chk({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " idle_ctrl_hold"}, 32'(bus.ctrl_sig), 32'(elast));
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        bus.cfg_valid     = 1'b0;
        bus.cfg_width     = 3'd0;
        bus.cfg_width_alt = 3'd0;
        bus.cfg_use_alt   = 1'b0;
        bus.cfg_clk_val   = 25'd0;
        bus.abort         = 1'b0;
        rst_n             = 1'b1;
        #1 rst_n = 1'b0;
        #7;
        chk("rst ctrl_sig", 32'(bus.ctrl_sig), 32'd1);
        chk("rst ready", 32'(bus.cfg_ready), 32'd1);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        chk("rst val", 32'(bus.val), 32'd0);
        chk("rst wanted", 32'(bus.wanted_cl_val), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        tick();
        chk("post_rst ready", 32'(bus.cfg_ready), 32'd1);

        // Scenario 1: width 2, clk 0x100, no alt phase.
        request(3'd2, 3'd1, 1'b0, 25'h000100);
        chk("s1 busy", 32'(bus.busy), 32'd1);
        chk("s1 ready", 32'(bus.cfg_ready), 32'd0);
        chk("s1 val", 32'(bus.val), 32'd2);
        chk("s1 wanted", 32'(bus.wanted_cl_val), 32'h100);
        chk("s1 earlier", 32'(bus.earlier_cl_val), 32'h0);
        run_and_check("s1", 16, 8, 0, 25, 3'd2);

        // Scenario 2: alt phase with width 4, clk 0x200.
        request(3'd3, 3'd4, 1'b1, 25'h000200);
        chk("s2 val1", 32'(bus.val1), 32'd4);
        chk("s2 wanted", 32'(bus.wanted_cl_val), 32'h200);
        chk("s2 earlier", 32'(bus.earlier_cl_val), 32'h100);
        run_and_check("s2", 16, 8, 8, 33, 3'd3);

        // Scenario 3: illegal widths are rejected with a one-cycle err.
        request(3'd5, 3'd1, 1'b0, 25'h000999);
        chk("s3a err", 32'(bus.err), 32'd1);
        chk("s3a ready", 32'(bus.cfg_ready), 32'd1);
        chk("s3a busy", 32'(bus.busy), 32'd0);
        chk("s3a ctrl", 32'(bus.ctrl_sig), 32'd3);
        chk("s3a val", 32'(bus.val), 32'd3);
        chk("s3a wanted", 32'(bus.wanted_cl_val), 32'h200);
        tick();
        chk("s3a err_pulse", 32'(bus.err), 32'd0);
        request(3'd0, 3'd1, 1'b0, 25'h000999);
        chk("s3b err", 32'(bus.err), 32'd1);
        chk("s3b val1", 32'(bus.val1), 32'd4);
        chk("s3b earlier", 32'(bus.earlier_cl_val), 32'h100);
        request(3'd2, 3'd7, 1'b1, 25'h000999);
        chk("s3c alt err", 32'(bus.err), 32'd1);
        chk("s3c ready", 32'(bus.cfg_ready), 32'd1);
        tick();

        // Scenario 4: same clock value, then abort in the 5th REL cycle.
        request(3'd1, 3'd2, 1'b0, 25'h000200);
        chk("s4 wanted", 32'(bus.wanted_cl_val), 32'h200);
        chk("s4 earlier", 32'(bus.earlier_cl_val), 32'h200);
        for (int i = 0; i < 20; i++) tick();
        chk("s4 pre_abort ctrl", 32'(bus.ctrl_sig), 32'd2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("s4 abort ctrl", 32'(bus.ctrl_sig), 32'd1);
        chk("s4 abort val", 32'(bus.val), 32'd1);
        run_and_check("s4", 16, 8, 0, 25, 3'd2);

        // Scenario 5: reset asserted during ALT.
        request(3'd1, 3'd2, 1'b1, 25'h000345);
        for (int i = 0; i < 26; i++) tick();
        chk("s5 in_alt ctrl", 32'(bus.ctrl_sig), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("s5 async ctrl", 32'(bus.ctrl_sig), 32'd1);
        chk("s5 async busy", 32'(bus.busy), 32'd0);
        chk("s5 async ready", 32'(bus.cfg_ready), 32'd1);
        chk("s5 async wanted", 32'(bus.wanted_cl_val), 32'h0);
        chk("s5 async val1", 32'(bus.val1), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s5 no_done", 32'(bus.done), 32'd0);
        end
        @(negedge clock);
        rst_n = 1'b1;
        tick();
        request(3'd4, 3'd1, 1'b0, 25'h000007);
        chk("s5 reaccept busy", 32'(bus.busy), 32'd1);
        chk("s5 reaccept earlier", 32'(bus.earlier_cl_val), 32'h0);
        chk("s5 reaccept wanted", 32'(bus.wanted_cl_val), 32'h7);
        run_and_check("s5", 16, 8, 0, 25, 3'd2);

        // Scenario 6: cfg_valid held high across a whole sequence.
        bus.cfg_width     = 3'd3;
        bus.cfg_width_alt = 3'd1;
        bus.cfg_use_alt   = 1'b0;
        bus.cfg_clk_val   = 25'h000abc;
        bus.cfg_valid     = 1'b1;
        tick();
        chk("s6 first accept", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i < 23) chk("s6 no_reaccept", 32'(bus.ctrl_sig == 3'd1 && i >= 16), 32'd0);
        end
        chk("s6 done", 32'(bus.done), 32'd1);
        tick();
        chk("s6 idle ready", 32'(bus.cfg_ready), 32'd1);
        chk("s6 idle busy", 32'(bus.busy), 32'd0);
        tick();
        bus.cfg_valid = 1'b0;
        chk("s6 second accept", 32'(bus.busy), 32'd1);
        chk("s6 second ctrl", 32'(bus.ctrl_sig), 32'd1);
        chk("s6 second earlier", 32'(bus.earlier_cl_val), 32'habc);
        run_and_check("s6", 16, 8, 0, 25, 3'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcw_config_seq.md
DCW_CONFIG_SEQ -- requirements
Module: dcw_config_seq

Interface
REQ-001 The block SHALL have parameter RESET_CYCLES, default 16, giving the cycles ctrl_sig is held at 1 per request (legal range 1..255).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 8, giving the cycles held in each of ctrl_sig 2 and 3 (legal range 1..255).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cfg_valid, input, 1 bit: a configuration request is present.
REQ-006 The block SHALL have port cfg_ready, output, 1 bit: the sequencer can accept a request.
REQ-007 The block SHALL have port cfg_width, input, 3 bits: primary datawidth code.
REQ-008 The block SHALL have port cfg_width_alt, input, 3 bits: alternate datawidth code.
REQ-009 The block SHALL have port cfg_use_alt, input, 1 bit: run the alternate-width phase.
REQ-010 The block SHALL have port cfg_clk_val, input, 25 bits: requested reference-clock increment.
REQ-011 The block SHALL have port abort, input, 1 bit: restart the current sequence.
REQ-012 The block SHALL have port ctrl_sig, output, 3 bits: command to the data channel wrapper.
REQ-013 The block SHALL have port val, output, 3 bits: primary width to the wrapper.
REQ-014 The block SHALL have port val1, output, 3 bits: alternate width to the wrapper.
REQ-015 The block SHALL have port wanted_cl_val, output, 25 bits: new clock increment.
REQ-016 The block SHALL have port earlier_cl_val, output, 25 bits: previously committed increment.
REQ-017 The block SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle pulse when a sequence completes.
REQ-019 The block SHALL have port err, output, 1 bit: one-cycle pulse when a request is rejected.

Function
REQ-020 The block SHALL implement FSM states IDLE, RST, REL, ALT, FIN, all outputs registered.
REQ-021 cfg_ready SHALL be 1 only in IDLE; busy SHALL be 1 in RST, REL, ALT and FIN.
REQ-022 A request SHALL be accepted on the edge where cfg_valid=1 and cfg_ready=1; cfg_valid while busy is ignored, not queued.
REQ-023 A width code of 0 or greater than 4 (cfg_width always; cfg_width_alt only when cfg_use_alt=1) SHALL reject the request: err=1 next cycle, state remains IDLE, no other output changes.
REQ-024 On accept: val<=cfg_width, val1<=cfg_width_alt, earlier_cl_val<=current wanted_cl_val, wanted_cl_val<=cfg_clk_val, counter<=0, state<=RST.
REQ-025 In RST, ctrl_sig SHALL be 1 for exactly RESET_CYCLES cycles, then the state SHALL move to REL.
REQ-026 In REL, ctrl_sig SHALL be 2 for exactly SETTLE_CYCLES cycles, then move to ALT if the latched use_alt=1, else to FIN.
REQ-027 In ALT, ctrl_sig SHALL be 3 for exactly SETTLE_CYCLES cycles, then move to FIN.
REQ-028 FIN SHALL last one cycle with done=1, then the state SHALL return to IDLE.
REQ-029 In IDLE and FIN, ctrl_sig SHALL hold its last driven value; it SHALL never be driven to 0 after reset.
REQ-030 The phase counter SHALL be 8 bits, clear on each state entry, and never wrap: the exit compare is at count == N-1.
REQ-031 abort=1 in RST, REL or ALT SHALL move the state to RST with counter=0 next cycle; latched widths and clock values are unchanged.
REQ-032 abort in IDLE or FIN SHALL be ignored; abort and cfg_valid together in IDLE SHALL accept the request.
REQ-033 Total latency from accept to the done pulse SHALL be RESET_CYCLES + SETTLE_CYCLES*(1+use_alt) + 1 cycles.
REQ-034 Submitting cfg_clk_val equal to the current wanted_cl_val SHALL be legal and yield wanted_cl_val == earlier_cl_val.

Reset
REQ-035 While rst_n=0, the block SHALL force the state to IDLE, ctrl_sig=1 (channel held in reset), val=0, val1=0, wanted_cl_val=0, earlier_cl_val=0, counter=0, busy=0, done=0, err=0, and cfg_ready=1.
REQ-036 Asserting rst_n mid-sequence SHALL discard the sequence immediately with no done pulse.
REQ-037 Reset deassertion SHALL take effect on the first rising clock edge after rst_n goes high.

Verification
REQ-038 Scenario 1 -- default parameters, width=2, clk=0x000100, use_alt=0 -> ctrl_sig 1 for 16 cycles, then 2 for 8 cycles, done 25 cycles after accept, wanted=0x000100, earlier=0.
REQ-039 Scenario 2 -- second request with clk=0x000200, use_alt=1, alt=4 -> earlier=0x000100, wanted=0x000200, val1=4, ctrl_sig 1(16), 2(8), 3(8), done 33 cycles after accept.
REQ-040 Scenario 3 -- cfg_width=5, then cfg_width=0 -> err pulse each time, cfg_ready stays 1, ctrl_sig and widths unchanged.
REQ-041 Scenario 4 -- abort in the 5th cycle of REL -> ctrl_sig returns to 1 for a full 16 cycles; done arrives 16+8+1 cycles after abort.
REQ-042 Scenario 5 -- rst_n low during ALT -> outputs take their reset values asynchronously, no done pulse, and a new request is accepted after release.
REQ-043 Scenario 6 -- cfg_valid held high through an entire sequence -> exactly one accept per IDLE visit, with the next accept in the cycle after FIN.
